// File: rtl/axis_splitter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_splitter_pkg
// Description : Shared helpers for the AXI-Stream packet splitter: segment
//               index width and per-segment length field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_splitter_pkg;

    // Width of a segment index; a single stream still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB position of length field k in a packed vector of w-bit fields.
    function automatic int field_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_reg_slice.sv
`default_nettype none
// ============================================================================
// Module      : axis_reg_slice
// Description : One-deep registered valid/ready slice. Accepts a new payload
//               whenever it is empty or its content is being consumed, so it
//               sustains one transfer per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_reg_slice
    import axis_splitter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             sreset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign in_ready  = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    // Load on every cycle the slice can accept; hold contents while stalled.
    always_ff @(posedge clk) begin
        if (sreset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (in_ready) begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_data <= in_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_splitter.sv
`default_nettype none
// ============================================================================
// Module      : axis_splitter
// Description : Splits each input AXI-Stream packet into NUM_STREAMS
//               consecutive segments, segment k leaving on output k as its
//               own tlast-terminated packet. Segment lengths (beats minus one)
//               are sampled from seg_len on the first beat of each packet; the
//               last segment runs until input tlast.
//               Optional macro AXIS_SPLITTER_ERR_EN adds the err_short pulse
//               that flags packets ending before the last segment.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_splitter
    import axis_splitter_pkg::*;
#(
    parameter int AXIS_BYTES  = 1,
    parameter int NUM_STREAMS = 2,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                                clk,
    input  logic                                sreset,
    input  logic [NUM_STREAMS*LEN_WIDTH-1:0]    seg_len,
    output logic                                axis_i_tready,
    input  logic                                axis_i_tvalid,
    input  logic                                axis_i_tlast,
    input  logic [AXIS_BYTES*8-1:0]             axis_i_tdata,
    input  logic [NUM_STREAMS-1:0]              axis_o_tready,
    output logic [NUM_STREAMS-1:0]              axis_o_tvalid,
    output logic [NUM_STREAMS-1:0]              axis_o_tlast,
    output logic [NUM_STREAMS*AXIS_BYTES*8-1:0] axis_o_tdata
`ifdef AXIS_SPLITTER_ERR_EN
    ,
    output logic                                err_short
`endif
);

    localparam int IDXW = idx_width(NUM_STREAMS);
    localparam int DW   = AXIS_BYTES * 8;
    localparam int PW   = IDXW + 1 + DW;
    localparam logic [IDXW-1:0] c_last_seg = IDXW'(NUM_STREAMS - 1);

    // Packet tracking state
    logic                             r_in_pkt;
    logic [IDXW-1:0]                  r_seg;
    logic [LEN_WIDTH-1:0]             r_rem;
    logic [NUM_STREAMS*LEN_WIDTH-1:0] r_len;

    // Lengths in effect for the current beat: live input on a packet's first
    // beat, the latched copy afterwards.
    logic [NUM_STREAMS*LEN_WIDTH-1:0] w_len_src;
    logic [LEN_WIDTH-1:0]             w_len_arr [NUM_STREAMS];
    logic [IDXW-1:0]                  w_cur_seg;
    logic [IDXW-1:0]                  w_next_seg;
    logic [LEN_WIDTH-1:0]             w_cur_rem;
    logic                             w_last_seg;
    logic                             w_cnt_end;
    logic                             w_out_last;
    logic                             w_accept;

    // Output slice signals
    logic                             w_slice_valid;
    logic                             w_slice_ready;
    logic [PW-1:0]                    w_slice_out;
    logic [IDXW-1:0]                  w_slice_dest;
    logic                             w_slice_last;
    logic [DW-1:0]                    w_slice_data;

    assign w_len_src = r_in_pkt ? r_len : seg_len;

    generate
        for (genvar k = 0; k < NUM_STREAMS; k++) begin : g_len
            assign w_len_arr[k] = w_len_src[field_lsb(k, LEN_WIDTH) +: LEN_WIDTH];
        end
    endgenerate

    assign w_cur_seg  = r_in_pkt ? r_seg : '0;
    assign w_cur_rem  = r_in_pkt ? r_rem : w_len_arr[0];
    assign w_last_seg = (w_cur_seg == c_last_seg);
    assign w_next_seg = w_last_seg ? w_cur_seg : (w_cur_seg + IDXW'(1));
    assign w_cnt_end  = !w_last_seg && (w_cur_rem == '0);
    assign w_out_last = axis_i_tlast || w_cnt_end;
    assign w_accept   = axis_i_tvalid && axis_i_tready;

    // Advance segment index and beat counter on each accepted input beat.
    always_ff @(posedge clk) begin
        if (sreset) begin
            r_in_pkt <= 1'b0;
            r_seg    <= '0;
            r_rem    <= '0;
            r_len    <= '0;
        end else if (w_accept) begin
            if (!r_in_pkt) begin
                r_len <= seg_len;
            end
            if (axis_i_tlast) begin
                r_in_pkt <= 1'b0;
                r_seg    <= '0;
                r_rem    <= '0;
            end else if (w_cnt_end) begin
                r_in_pkt <= 1'b1;
                r_seg    <= w_next_seg;
                r_rem    <= w_len_arr[w_next_seg];
            end else begin
                r_in_pkt <= 1'b1;
                r_seg    <= w_cur_seg;
                r_rem    <= w_cur_rem - LEN_WIDTH'(1);
            end
        end
    end

    axis_reg_slice #(
        .WIDTH (PW)
    ) u_slice (
        .clk       (clk),
        .sreset    (sreset),
        .in_valid  (axis_i_tvalid),
        .in_ready  (w_slice_ready),
        .in_data   ({w_cur_seg, w_out_last, axis_i_tdata}),
        .out_valid (w_slice_valid),
        .out_ready (axis_o_tready[w_slice_dest]),
        .out_data  (w_slice_out)
    );

    assign axis_i_tready = w_slice_ready;
    assign w_slice_dest  = w_slice_out[PW-1 -: IDXW];
    assign w_slice_last  = w_slice_out[DW];
    assign w_slice_data  = w_slice_out[DW-1:0];

    // Demultiplex the single slice onto the per-stream outputs.
    generate
        for (genvar k = 0; k < NUM_STREAMS; k++) begin : g_out
            assign axis_o_tvalid[k]          = w_slice_valid && (w_slice_dest == IDXW'(k));
            assign axis_o_tlast[k]           = axis_o_tvalid[k] && w_slice_last;
            assign axis_o_tdata[k*DW +: DW]  = w_slice_data;
        end
    endgenerate

`ifdef AXIS_SPLITTER_ERR_EN
    logic r_err_short;

    // Flag a packet whose tlast arrives before the final segment.
    always_ff @(posedge clk) begin
        if (sreset) begin
            r_err_short <= 1'b0;
        end else begin
            r_err_short <= w_accept && axis_i_tlast && !w_last_seg;
        end
    end

    assign err_short = r_err_short;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_splitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_splitter
// Description : Self-checking bench for axis_splitter (3-stream and 1-stream
//               instances) against a segment-boundary reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_splitter;

    localparam int NS = 3;
    localparam int LW = 16;
    localparam int AB = 2;
    localparam int DW = AB * 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              sreset = 1'b1;
    logic [NS*LW-1:0]  seg_len = '0;
    logic              i_tready;
    logic              i_tvalid = 1'b0;
    logic              i_tlast = 1'b0;
    logic [DW-1:0]     i_tdata = '0;
    logic [NS-1:0]     o_tready;
    logic [NS-1:0]     o_tvalid;
    logic [NS-1:0]     o_tlast;
    logic [NS*DW-1:0]  o_tdata;
`ifdef AXIS_SPLITTER_ERR_EN
    logic              err_short;
`endif

    // Single-stream instance signals
    logic [LW-1:0]     p_seg_len = '0;
    logic              p_i_tready;
    logic              p_i_tvalid = 1'b0;
    logic              p_i_tlast = 1'b0;
    logic [7:0]        p_i_tdata = '0;
    logic [0:0]        p_o_tready = 1'b1;
    logic [0:0]        p_o_tvalid;
    logic [0:0]        p_o_tlast;
    logic [7:0]        p_o_tdata;
`ifdef AXIS_SPLITTER_ERR_EN
    logic              p_err_short;
`endif

    axis_splitter #(.AXIS_BYTES(AB), .NUM_STREAMS(NS), .LEN_WIDTH(LW)) dut3 (
        .clk(clk), .sreset(sreset), .seg_len(seg_len),
        .axis_i_tready(i_tready), .axis_i_tvalid(i_tvalid),
        .axis_i_tlast(i_tlast), .axis_i_tdata(i_tdata),
        .axis_o_tready(o_tready), .axis_o_tvalid(o_tvalid),
        .axis_o_tlast(o_tlast), .axis_o_tdata(o_tdata)
`ifdef AXIS_SPLITTER_ERR_EN
        , .err_short(err_short)
`endif
    );

    axis_splitter #(.AXIS_BYTES(1), .NUM_STREAMS(1), .LEN_WIDTH(LW)) dut1 (
        .clk(clk), .sreset(sreset), .seg_len(p_seg_len),
        .axis_i_tready(p_i_tready), .axis_i_tvalid(p_i_tvalid),
        .axis_i_tlast(p_i_tlast), .axis_i_tdata(p_i_tdata),
        .axis_o_tready(p_o_tready), .axis_o_tvalid(p_o_tvalid),
        .axis_o_tlast(p_o_tlast), .axis_o_tdata(p_o_tdata)
`ifdef AXIS_SPLITTER_ERR_EN
        , .err_short(p_err_short)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
        bit            lat;
    } exp_t;

    exp_t exp_q [NS][$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rdy_mode = 0;      // 0: all ready, 1: random, 2: none ready
    bit   err_pending = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output ready pattern, updated just after each rising edge.
    initial begin
        o_tready = '1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       o_tready = '1;
                1:       o_tready = NS'($urandom);
                default: o_tready = '0;
            endcase
        end
    end

    // Output monitor: ordering, content, latency, stall stability, err pulse.
    logic [NS-1:0] held = '0;
    logic [DW-1:0] held_d [NS];
    logic          held_l [NS];
    always @(negedge clk) begin
        if (sreset) begin
            held = '0;
        end else begin
            check("onehot_valid", 64'($onehot0(o_tvalid)), 64'd1);
            for (int k = 0; k < NS; k++) begin
                if (held[k]) begin
                    check($sformatf("hold_valid%0d", k), 64'(o_tvalid[k]), 64'd1);
                    check($sformatf("hold_data%0d", k), 64'(o_tdata[k*DW +: DW]), 64'(held_d[k]));
                    check($sformatf("hold_last%0d", k), 64'(o_tlast[k]), 64'(held_l[k]));
                end
                if (o_tvalid[k] && o_tready[k]) begin
                    held[k] = 1'b0;
                    if (exp_q[k].size() == 0) begin
                        check($sformatf("spurious%0d", k), 64'(o_tdata[k*DW +: DW]), 64'hDEAD_BEEF_0000_0000);
                    end else begin
                        exp_t e;
                        e = exp_q[k].pop_front();
                        check($sformatf("data%0d", k), 64'(o_tdata[k*DW +: DW]), 64'(e.data));
                        check($sformatf("last%0d", k), 64'(o_tlast[k]), 64'(e.last));
                        if (e.lat) check($sformatf("latency%0d", k), 64'(cyc), 64'(e.cyc + 1));
                    end
                end else begin
                    held[k]   = o_tvalid[k];
                    held_d[k] = o_tdata[k*DW +: DW];
                    held_l[k] = o_tlast[k];
                end
            end
        end
`ifdef AXIS_SPLITTER_ERR_EN
        check("err_short", 64'(err_short), 64'(err_pending));
`endif
        err_pending = 1'b0;
    end

    // Wait (bounded) at falling edges until the input is ready.
    task automatic wait_ready(output int waited);
        waited = 0;
        @(negedge clk);
        while (!i_tready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!i_tready) begin
            check("accept_timeout", 64'(i_tready), 64'd1);
            $fatal(1, "FAIL accept_timeout: input never became ready");
        end
    endtask

    // Send one packet; the model derives each beat's stream and tlast from
    // cumulative segment boundaries b0 = l0+1, b1 = b0+l1+1.
    task automatic send_pkt(input int n, input int l0, input int l1, input int pkt_id,
                            input bit gaps, input bit lat, input bit midchg);
        int   b0, b1, w, strm;
        bit   is_short;
        exp_t e;
        b0 = l0 + 1;
        b1 = b0 + l1 + 1;
        is_short = (n <= b1);
        seg_len = {LW'($urandom), LW'(l1), LW'(l0)};
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                i_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            i_tvalid = 1'b1;
            i_tdata  = {pkt_id[7:0], i[7:0]};
            i_tlast  = (i == n - 1);
            wait_ready(w);
            if (lat) check("full_rate", 64'(w), 64'd0);
            strm   = (i < b0) ? 0 : (i < b1) ? 1 : 2;
            e.data = i_tdata;
            e.last = (i == n - 1) || (i == b0 - 1) || (i == b1 - 1);
            e.cyc  = cyc;
            e.lat  = lat;
            exp_q[strm].push_back(e);
            @(posedge clk);
            #1;
            if (midchg && i == 0) seg_len = NS*LW'({$urandom, $urandom});
        end
        i_tvalid    = 1'b0;
        i_tlast     = 1'b0;
        err_pending = is_short;
    endtask

    task automatic drain(input string tag);
        int w;
        rdy_mode = 0;
        w = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        for (int k = 0; k < NS; k++)
            check($sformatf("%s_pending%0d", tag, k), 64'(exp_q[k].size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        exp_t e;

        // Reset and reset-state checks
        sreset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sreset = 1'b0;
        @(negedge clk);
        check("rst_tvalid", 64'(o_tvalid), 64'd0);
        check("rst_tlast", 64'(o_tlast), 64'd0);
        check("rst_tdata", 64'(o_tdata), 64'd0);
        check("rst_tready", 64'(i_tready), 64'd1);
        check("rst1_tvalid", 64'(p_o_tvalid), 64'd0);
        check("rst1_tready", 64'(p_i_tready), 64'd1);
`ifdef AXIS_SPLITTER_ERR_EN
        check("rst_err", 64'(err_short), 64'd0);
`endif

        // Single-stream pass-through, 5 beats, one-cycle latency
        @(posedge clk);
        #1;
        for (int i = 0; i <= 5; i++) begin
            p_i_tvalid = (i < 5);
            p_i_tdata  = 8'(8'h10 + i);
            p_i_tlast  = (i == 4);
            @(negedge clk);
            if (i < 5) check("p_tready", 64'(p_i_tready), 64'd1);
            if (i > 0) begin
                check("p_tvalid", 64'(p_o_tvalid), 64'd1);
                check("p_tdata", 64'(p_o_tdata), 64'(8'h10 + i - 1));
                check("p_tlast", 64'(p_o_tlast), 64'(i == 5));
            end
            @(posedge clk);
            #1;
        end
        p_i_tvalid = 1'b0;
        @(negedge clk);
        check("p_idle", 64'(p_o_tvalid), 64'd0);
        @(posedge clk);
        #1;

        // Full packet: seg0 = 3 beats, seg1 = 2 beats, seg2 = rest
        send_pkt(8, 2, 1, 0, 1'b0, 1'b1, 1'b0);
        drain("full");

        // Short packet: stream 2 silent, err pulse
        send_pkt(4, 2, 1, 1, 1'b0, 1'b1, 1'b0);
        drain("short");

        // Segment end coincides with tlast in seg1: still short
        send_pkt(5, 2, 1, 2, 1'b0, 1'b1, 1'b0);
        drain("edge");

        // seg_len changed mid-packet is ignored; new value used next packet
        send_pkt(9, 1, 3, 3, 1'b0, 1'b1, 1'b1);
        send_pkt(7, 3, 0, 4, 1'b0, 1'b1, 1'b0);
        drain("midchg");

        // Reset after two beats of a packet
        seg_len  = {LW'(0), LW'(1), LW'(2)};
        i_tvalid = 1'b1;
        i_tdata  = 16'h0500;
        i_tlast  = 1'b0;
        wait_ready(w);
        e.data = i_tdata; e.last = 1'b0; e.cyc = cyc; e.lat = 1'b1;
        exp_q[0].push_back(e);
        @(posedge clk);
        #1;
        i_tdata = 16'h0501;
        wait_ready(w);
        rdy_mode = 2;
        @(posedge clk);
        #1;
        sreset   = 1'b1;
        i_tvalid = 1'b0;
        @(posedge clk);
        #1;
        sreset = 1'b0;
        @(negedge clk);
        check("rstmid_tvalid", 64'(o_tvalid), 64'd0);
        check("rstmid_tlast", 64'(o_tlast), 64'd0);
        check("rstmid_tready", 64'(i_tready), 64'd1);
        for (int k = 0; k < NS; k++) exp_q[k].delete();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_pkt(6, 1, 1, 6, 1'b0, 1'b1, 1'b0);
        drain("after_rst");

        // Randomised packets with random output stalls and input gaps
        rdy_mode = 1;
        for (int p = 0; p < 100; p++) begin
            send_pkt($urandom_range(1, 12), $urandom_range(0, 4), $urandom_range(0, 4),
                     p + 16, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        end
        drain("random");

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
